// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding and bus-level constants.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        IGNORE
    } i2c_state_e;

    localparam logic       I2C_ACK   = 1'b0;
    localparam logic       I2C_NACK  = 1'b1;
    localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes SCL/SDA into core_clk and flags SCL edges and START/STOP conditions.
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic core_clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_pipe;
    logic [SYNC_STAGES-1:0] sda_pipe;
    logic                   scl;
    logic                   scl_q;
    logic                   sda_q;

    // Flops come out of reset at the idle-bus level so no edge is seen at release.
    always_ff @(posedge core_clk) begin
        if (rst) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl_in};
            sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_in};
            scl_q    <= scl;
            sda_q    <= sda;
        end
    end

    assign scl      = scl_pipe[SYNC_STAGES-1];
    assign sda      = sda_pipe[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    // SCL must be high on both sides of the SDA edge to count as a bus condition.
    assign start    = scl & scl_q & sda_q & ~sda;
    assign stop     = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: address match, write bytes into the RX FIFO, serve reads from the TX FIFO.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       core_clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic [7:0] rx_data,
    output logic       rx_wr,
    input  logic       rx_full,
    input  logic [7:0] tx_data,
    output logic       tx_rd,
    input  logic       tx_empty,
    output logic       busy,
    output logic       rw
);
    import i2c_pkg::*;

    logic sda, scl_rise, scl_fall, start, stop;

    i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
        .core_clk (core_clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    i2c_state_e state, state_d;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic [7:0] shreg, shreg_d, rx_data_d;
    logic       sda_out_d, rx_wr_d, tx_rd_d, busy_d, rw_d;
    // ack_drv: ACK bit already on the bus (second SCL fall ends the slot).
    // ack_ok: RX byte accepted / TX byte acknowledged by the master.
    logic       ack_drv, ack_drv_d, ack_ok, ack_ok_d;

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        shreg_d   = shreg;
        rx_data_d = rx_data;
        sda_out_d = sda_out;
        busy_d    = busy;
        rw_d      = rw;
        ack_drv_d = ack_drv;
        ack_ok_d  = ack_ok;
        rx_wr_d   = 1'b0;
        tx_rd_d   = 1'b0;

        case (state)
            IDLE: bit_cnt_d = 3'd7;
            ADDR: begin
                if (scl_rise) begin
                    shreg_d = {shreg[6:0], sda};
                    if (bit_cnt == 3'd0) begin
                        bit_cnt_d = 3'd7;
                        ack_drv_d = 1'b0;
                        if (shreg[6:0] == TARGET_ADDR) begin
                            rw_d    = sda;
                            busy_d  = 1'b1;
                            state_d = ADDR_ACK;
                        end else begin
                            state_d = IGNORE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt - 3'd1;
                    end
                end
            end
            ADDR_ACK: begin
                if (scl_fall) begin
                    if (!ack_drv) begin
                        sda_out_d = I2C_ACK;
                        ack_drv_d = 1'b1;
                        if (rw) begin
                            tx_rd_d = ~tx_empty;
                            shreg_d = tx_empty ? FILL_BYTE : tx_data;
                        end
                    end else begin
                        ack_drv_d = 1'b0;
                        if (rw) begin
                            sda_out_d = shreg[7];
                            state_d   = TX_BYTE;
                        end else begin
                            sda_out_d = 1'b1;
                            state_d   = RX_BYTE;
                        end
                    end
                end
            end
            RX_BYTE: begin
                if (scl_rise) begin
                    shreg_d = {shreg[6:0], sda};
                    if (bit_cnt == 3'd0) begin
                        bit_cnt_d = 3'd7;
                        ack_drv_d = 1'b0;
                        ack_ok_d  = ~rx_full;
                        state_d   = RX_ACK;
                        if (!rx_full) begin
                            rx_data_d = {shreg[6:0], sda};
                            rx_wr_d   = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt - 3'd1;
                    end
                end
            end
            RX_ACK: begin
                if (scl_fall) begin
                    if (!ack_drv) begin
                        sda_out_d = ack_ok ? I2C_ACK : I2C_NACK;
                        ack_drv_d = 1'b1;
                    end else begin
                        sda_out_d = 1'b1;
                        ack_drv_d = 1'b0;
                        state_d   = RX_BYTE;
                    end
                end
            end
            TX_BYTE: begin
                if (scl_fall) begin
                    if (bit_cnt == 3'd0) begin
                        sda_out_d = 1'b1;
                        bit_cnt_d = 3'd7;
                        ack_ok_d  = 1'b0;
                        state_d   = TX_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt - 3'd1;
                        shreg_d   = {shreg[6:0], 1'b1};
                        sda_out_d = shreg[6];
                    end
                end
            end
            TX_ACK: begin
                if (scl_rise && !ack_ok) begin
                    if (sda == I2C_ACK) begin
                        ack_ok_d = 1'b1;
                        tx_rd_d  = ~tx_empty;
                        shreg_d  = tx_empty ? FILL_BYTE : tx_data;
                    end else begin
                        state_d = IGNORE;
                    end
                end else if (scl_fall && ack_ok) begin
                    ack_ok_d  = 1'b0;
                    sda_out_d = shreg[7];
                    state_d   = TX_BYTE;
                end
            end
            IGNORE: sda_out_d = 1'b1;
            default: state_d = IDLE;
        endcase

        // Bus conditions and enable override whatever the byte logic decided.
        if (stop) begin
            state_d   = IDLE;
            sda_out_d = 1'b1;
            busy_d    = 1'b0;
        end else if (start) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd7;
            sda_out_d = 1'b1;
            ack_drv_d = 1'b0;
        end
        if (!enable) begin
            state_d   = IDLE;
            sda_out_d = 1'b1;
            busy_d    = 1'b0;
            rx_wr_d   = 1'b0;
            tx_rd_d   = 1'b0;
        end
    end

    always_ff @(posedge core_clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= 3'd7;
            shreg   <= 8'h00;
            rx_data <= 8'h00;
            sda_out <= 1'b1;
            rx_wr   <= 1'b0;
            tx_rd   <= 1'b0;
            busy    <= 1'b0;
            rw      <= 1'b0;
            ack_drv <= 1'b0;
            ack_ok  <= 1'b0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            shreg   <= shreg_d;
            rx_data <= rx_data_d;
            sda_out <= sda_out_d;
            rx_wr   <= rx_wr_d;
            tx_rd   <= tx_rd_d;
            busy    <= busy_d;
            rw      <= rw_d;
            ack_drv <= ack_drv_d;
            ack_ok  <= ack_ok_d;
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged master on a wired-AND bus against a transaction-level model.
module tb_i2c_target;
    localparam int Q = 8;   // core_clk cycles per quarter SCL period

    logic       core_clk = 1'b0;
    logic       rst = 1'b1, enable = 1'b1, rx_full = 1'b0;
    logic       m_scl = 1'b1, m_sda = 1'b1;
    logic       scl_in, sda_in, sda_out, rx_wr, tx_rd, tx_empty, busy, rw;
    logic [7:0] rx_data, tx_data;

    assign scl_in = m_scl;
    assign sda_in = m_sda & sda_out;

    always #5 core_clk = ~core_clk;

    i2c_target #(.TARGET_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .core_clk (core_clk),
        .rst      (rst),
        .enable   (enable),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_out  (sda_out),
        .rx_data  (rx_data),
        .rx_wr    (rx_wr),
        .rx_full  (rx_full),
        .tx_data  (tx_data),
        .tx_rd    (tx_rd),
        .tx_empty (tx_empty),
        .busy     (busy),
        .rw       (rw)
    );

    // TX FIFO emulation: tx_mem is filled by the stimulus, rd_ptr advances on pops.
    logic [7:0] tx_mem[$];
    int         rd_ptr = 0;
    always @(posedge core_clk) if (tx_rd) rd_ptr <= rd_ptr + 1;
    always @(negedge core_clk) begin
        tx_empty <= (rd_ptr >= tx_mem.size());
        tx_data  <= (rd_ptr < tx_mem.size()) ? tx_mem[rd_ptr] : 8'h00;
    end

    // Observation of the FIFO-side pulses and SDA activity.
    logic [7:0] got_rx[$];
    int   rx_cnt = 0, tx_cnt = 0, low_cnt = 0, bad_cnt = 0;
    logic rx_wr_q = 1'b0, tx_rd_q = 1'b0;
    always @(posedge core_clk) begin
        if (rx_wr) got_rx.push_back(rx_data);
        rx_cnt  <= rx_cnt + int'(rx_wr);
        tx_cnt  <= tx_cnt + int'(tx_rd);
        low_cnt <= low_cnt + int'(!sda_out);
        bad_cnt <= bad_cnt + int'(rx_wr && tx_rd) + int'(rx_wr && rx_wr_q) + int'(tx_rd && tx_rd_q);
        rx_wr_q <= rx_wr;
        tx_rd_q <= tx_rd;
    end

    // Reference model state
    logic [7:0] model_fifo[$];
    logic [7:0] exp_rx[$];
    logic [7:0] wr_bytes[$];
    int         exp_tx = 0;
    int         n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic q_wait();
        repeat (Q) @(posedge core_clk);
    endtask

    task automatic m_start();
        m_sda = 1'b1; q_wait();
        m_scl = 1'b1; q_wait();
        m_sda = 1'b0; q_wait();
        m_scl = 1'b0; q_wait();
    endtask

    task automatic m_stop();
        m_sda = 1'b0; q_wait();
        m_scl = 1'b1; q_wait();
        m_sda = 1'b1; q_wait();
    endtask

    task automatic clk_bit(input logic b, output logic s);
        m_sda = b; q_wait();
        m_scl = 1'b1; q_wait();
        @(negedge core_clk) s = sda_in;
        q_wait();
        m_scl = 1'b0; q_wait();
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(nack, s);
    endtask

    // Write frame: address acked only on match; data acked only on match with room in the RX FIFO.
    task automatic do_write(input logic [6:0] a, input logic full);
        logic ack, match, exp_ack;
        match   = (a == 7'h50);
        rx_full = full;
        m_start();
        wr_byte({a, 1'b0}, ack);
        chk("wr_addr_ack", ack, match ? 1'b0 : 1'b1);
        if (match) begin
            chk("wr_busy", busy, 1'b1);
            chk("wr_rw", rw, 1'b0);
        end
        foreach (wr_bytes[i]) begin
            wr_byte(wr_bytes[i], ack);
            exp_ack = !(match && !full);
            chk("wr_data_ack", ack, exp_ack);
            if (!exp_ack) exp_rx.push_back(wr_bytes[i]);
        end
        rx_full = 1'b0;
    endtask

    // Read frame: master acks all but the last byte; empty FIFO yields the fill byte.
    task automatic do_read(input int n);
        logic       ack;
        logic [7:0] d, e;
        m_start();
        wr_byte(8'hA1, ack);
        chk("rd_addr_ack", ack, 1'b0);
        chk("rd_rw", rw, 1'b1);
        for (int i = 0; i < n; i++) begin
            rd_byte(i == n - 1, d);
            if (model_fifo.size() > 0) begin
                e = model_fifo.pop_front();
                exp_tx++;
            end else begin
                e = 8'hFF;
            end
            chk("rd_data", d, e);
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_mem.push_back(b);
        model_fifo.push_back(b);
    endtask

    initial begin
        int         r0, t0, l0, n, k;
        logic [6:0] a;
        logic       ack;

        repeat (4) @(posedge core_clk);
        @(negedge core_clk);
        chk("rst_sda_out", sda_out, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rw", rw, 1'b0);
        chk("rst_pulses", {rx_wr, tx_rd}, 2'b00);
        chk("rst_rx_data", rx_data, 8'h00);
        rst = 1'b0;
        repeat (4) @(posedge core_clk);

        // Plain write of two bytes
        r0 = rx_cnt;
        wr_bytes = '{8'h3C, 8'hC3};
        do_write(7'h50, 1'b0);
        m_stop();
        chk("t1_busy_after_stop", busy, 1'b0);
        chk("t1_rx_cnt", rx_cnt - r0, 2);

        // Read two bytes, NACK the last
        t0 = tx_cnt;
        push_tx(8'h5A); push_tx(8'hA5);
        do_read(2);
        chk("t2_ignore_sda", sda_out, 1'b1);
        m_stop();
        chk("t2_tx_cnt", tx_cnt - t0, 2);

        // Foreign address: bus never pulled low
        r0 = rx_cnt; t0 = tx_cnt; l0 = low_cnt;
        wr_bytes = '{8'h12};
        do_write(7'h51, 1'b0);
        chk("t3_busy", busy, 1'b0);
        m_stop();
        chk("t3_sda_never_low", low_cnt - l0, 0);
        chk("t3_no_pulses", (rx_cnt - r0) + (tx_cnt - t0), 0);

        // RX FIFO full: NACK, byte dropped
        r0 = rx_cnt;
        wr_bytes = '{8'h11};
        do_write(7'h50, 1'b1);
        m_stop();
        chk("t4_no_rx_wr", rx_cnt - r0, 0);

        // Empty TX FIFO: fill byte, no pop
        t0 = tx_cnt;
        do_read(1);
        m_stop();
        chk("t5_no_tx_rd", tx_cnt - t0, 0);

        // Write then repeated start into a read
        r0 = rx_cnt; t0 = tx_cnt;
        wr_bytes = '{8'h07};
        do_write(7'h50, 1'b0);
        push_tx(8'h96);
        do_read(1);
        m_stop();
        chk("t6_rx_cnt", rx_cnt - r0, 1);
        chk("t6_tx_cnt", tx_cnt - t0, 1);

        // Randomized frames; reads never push more than they consume so the FIFO ends empty
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                a = ($urandom_range(0, 3) == 0) ? (7'h50 ^ 7'($urandom_range(1, 127))) : 7'h50;
                wr_bytes.delete();
                for (int j = 0; j < n; j++) wr_bytes.push_back(8'($urandom));
                do_write(a, $urandom_range(0, 3) == 0);
            end else begin
                k = $urandom_range(0, n);
                for (int j = 0; j < k; j++) push_tx(8'($urandom));
                do_read(n);
            end
            m_stop();
            chk("rnd_busy_after_stop", busy, 1'b0);
        end

        // Drop enable while the target drives a 0 data bit
        push_tx(8'h00);
        m_start();
        wr_byte(8'hA1, ack);
        void'(model_fifo.pop_front());
        exp_tx++;
        chk("en_drive_low", sda_out, 1'b0);
        enable = 1'b0;
        @(posedge core_clk);
        @(negedge core_clk);
        chk("en_release", sda_out, 1'b1);
        enable = 1'b1;
        m_stop();

        // Synchronous reset in the middle of a read byte
        push_tx(8'h00);
        m_start();
        wr_byte(8'hA1, ack);
        void'(model_fifo.pop_front());
        exp_tx++;
        chk("rst_mid_drive_low", sda_out, 1'b0);
        rst = 1'b1;
        @(posedge core_clk);
        @(negedge core_clk);
        rst = 1'b0;
        chk("rst_mid_sda_out", sda_out, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_rw", rw, 1'b0);
        m_stop();

        // Target must be back in IDLE and answer a fresh frame
        wr_bytes = '{8'h42};
        do_write(7'h50, 1'b0);
        m_stop();
        repeat (4) @(posedge core_clk);
        @(negedge core_clk);

        chk("rx_total", got_rx.size(), exp_rx.size());
        foreach (exp_rx[i]) if (i < got_rx.size()) chk("rx_byte", got_rx[i], exp_rx[i]);
        chk("tx_total", tx_cnt, exp_tx);
        chk("pulse_rules", bad_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
